bird_ctrl: RTL
==============

# bird_ctrl

Motion controller driving the bird column of the LED-matrix game. It synchronises and edge-detects the raw flap key, times gravity ticks, and runs the game-level IDLE/RUN/OVER state machine. It produces the single-cycle `flap` and `fall` strobes consumed by every bird-column cell's `in` and `fall` inputs. It guarantees those two strobes are never asserted together.

## Interface
- `FALL_PERIOD`, default 25_000_000: clk cycles between gravity ticks (0.5 s at 50 MHz). The bench overrides it to 8. Must be ≥ 2.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `key_raw` input 1: raw flap button, asynchronous, 1 = pressed.
- `top_lit` input 1: bird occupies the top row.
- `bottom_lit` input 1: bird occupies the bottom row.
- `collide` input 1: a pipe cell overlaps the lit bird cell (level).
- `flap` output 1: one-cycle pulse that moves the bird up one row.
- `fall` output 1: one-cycle pulse that moves the bird down one row.
- `running` output 1: high while in RUN.
- `game_over` output 1: high while in OVER.

## Operation
- **Key path**
  - Two-flop synchroniser: `key_raw` → `key_s`, then a delay flop `key_d`.
  - `press = key_s & ~key_d`: one cycle per physical press, regardless of hold length.
- **FSM states:** IDLE, RUN, OVER. Reset state is IDLE.
- **IDLE**
  - Counter is held at 0; `flap` and `fall` stay 0.
  - `press` → RUN. The starting press does not generate a `flap`.
- **RUN**
  - The counter increments every cycle from 0 to FALL_PERIOD-1, then wraps to 0.
  - `tick` = counter at FALL_PERIOD-1.
  - Priority per cycle, highest first:
    1. `collide` → OVER. No `flap` or `fall` this cycle.
    2. `press` → counter cleared to 0 (grace period). `flap` is issued unless `top_lit`; when `top_lit`, the flap is swallowed but the counter is still cleared.
    3. `tick`: if `bottom_lit` → OVER with no `fall`; otherwise `fall` is issued.
    4. Otherwise hold state.
  - `press` and `tick` in the same cycle: the flap wins and no `fall` is issued. `flap` and `fall` are therefore mutually exclusive by construction.
- **OVER**
  - Sticky until `reset`; `press` is ignored.
  - Counter frozen; `flap` and `fall` are 0.
- **Widths:** counter width is `$clog2(FALL_PERIOD)`. The terminal compare is against FALL_PERIOD-1 at full counter width, with no truncation.

## Timing
- **Reset values**
  - `flap`, `fall`, `running`, `game_over` = 0.
  - Counter = 0.
  - Both synchroniser flops and `key_d` = 1, so a key held through reset is not a press. A fresh press is needed once the key is released.
- **Registered outputs:** `flap` and `fall` are registered; `running` and `game_over` decode the state register.
- **Key latency:** `key_raw` first sampled high at edge n → `press` high between edges n+1 and n+2 → `flap` high for exactly one cycle after edge n+2.
- **Entering RUN:** RUN entered at edge e (counter 0) → first `fall` after edge e+FALL_PERIOD. Later `fall` pulses are spaced FALL_PERIOD cycles apart, absent presses.
- **After a flap:** `flap` registered at edge f → next `fall` after edge f+FALL_PERIOD.
- **Game end:** `collide`, or `tick` with `bottom_lit`, sampled at edge c → `running` = 0 and `game_over` = 1 after edge c.
- **Reset mid-game:** `reset` sampled at any edge forces IDLE and clears all outputs after that same edge. Takes priority over every other event.

## Structure
- Package `bird_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, OVER} game_state_t`.
  - A default-period constant `BIRD_FALL_PERIOD`.
- Sub-module `key_edge` (clk, reset, `key_raw` → `press`) holds the synchroniser, `key_d`, and the reset-to-1 rule. It is instantiated once and is reusable for a future restart button.
- Top level `bird_ctrl` holds the counter, FSM and output registers.

## Test plan (FALL_PERIOD=8)
- **Start and gravity:** reset, `key_raw` pulse held 5 cycles → `running` = 1, no `flap`. First `fall` 8 cycles after RUN entry, then every 8 cycles, each exactly 1 cycle wide.
- **Flap and grace:** in RUN, press at counter=5 → `flap` 1 cycle wide, 3 edges after the `key_raw` rise. Next `fall` 8 cycles after `flap`. Holding the key for 20 cycles yields exactly one `flap`.
- **Simultaneous press and tick:** press timed so `press` coincides with counter=7 → `flap` = 1 and `fall` = 0 that cycle. `flap & fall` is never 1 across the whole run (assertion).
- **Boundaries:**
  - `top_lit` = 1 plus press → no `flap`, counter still cleared.
  - `bottom_lit` = 1 at tick → no `fall`, `game_over` = 1 next cycle.
- **Collision:** `collide` = 1 for 1 cycle during a press → OVER, `flap` = 0. Subsequent presses leave `game_over` = 1 and `flap`/`fall` = 0.
- **Reset mid-game:** assert `reset` with counter=4 and key held → all outputs 0. Releasing reset with the key still held gives no start. Release the key, press again → RUN.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared types and constants for the bird-column motion controller.
// The game-level state encoding lives here so other blocks can decode it.
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } game_state_t;

    // 0.5 s between gravity ticks with a 50 MHz clock
    localparam int BIRD_FALL_PERIOD = 25_000_000;

endpackage

// File: rtl/bird_ctrl_if.sv
// Game-side signals of the bird controller: player/board inputs and the
// movement strobes plus game status that drive the bird column.
interface bird_ctrl_if;

    logic key_raw;
    logic top_lit;
    logic bottom_lit;
    logic collide;
    logic flap;
    logic fall;
    logic running;
    logic game_over;

    modport master (
        output key_raw,
        output top_lit,
        output bottom_lit,
        output collide,
        input  flap,
        input  fall,
        input  running,
        input  game_over
    );

    modport slave (
        input  key_raw,
        input  top_lit,
        input  bottom_lit,
        input  collide,
        output flap,
        output fall,
        output running,
        output game_over
    );

endinterface

// File: rtl/key_edge.sv
// Synchronises an asynchronous push button and emits a one-cycle pulse per press.
// All flops reset to 1 so a key held through reset never counts as a press.
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic press
);

    logic key_meta;
    logic key_s;
    logic key_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
            key_d    <= 1'b1;
        end else begin
            key_meta <= key_raw;
            key_s    <= key_meta;
            key_d    <= key_s;
        end
    end

    assign press = key_s & ~key_d;

endmodule

// File: rtl/bird_ctrl.sv
// Bird motion controller: gravity timer plus IDLE/RUN/OVER game state machine
// producing mutually exclusive one-cycle flap and fall strobes.
module bird_ctrl
    import bird_pkg::*;
#(
    parameter int FALL_PERIOD = BIRD_FALL_PERIOD
) (
    input  logic        clk,
    input  logic        reset,
    bird_ctrl_if.slave  bus
);

    localparam int CW = $clog2(FALL_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(FALL_PERIOD - 1);

    game_state_t   state;
    logic [CW-1:0] count;
    logic          flap_q;
    logic          fall_q;
    logic          press;
    logic          tick;

    key_edge u_key_edge (
        .clk     (clk),
        .reset   (reset),
        .key_raw (bus.key_raw),
        .press   (press)
    );

    assign tick = (count == LAST);

    // One if/else chain per cycle means flap and fall can never both be set:
    // collision beats press, and a press beats a simultaneous gravity tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            flap_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            flap_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (press) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.collide) begin
                        state <= OVER;
                    end else if (press) begin
                        count  <= '0;
                        flap_q <= ~bus.top_lit;
                    end else if (tick) begin
                        count <= '0;
                        if (bus.bottom_lit) begin
                            state <= OVER;
                        end else begin
                            fall_q <= 1'b1;
                        end
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.flap      = flap_q;
    assign bus.fall      = fall_q;
    assign bus.running   = (state == RUN);
    assign bus.game_over = (state == OVER);

endmodule
